booth_mul_seq: RTL and testbench
================================

# booth_mul_seq

Sequential radix-4 Booth multiplier for signed operands, one Booth digit per clock. It sits directly downstream of `booth_enc`. It forms the overlapping 3-bit multiplier window each cycle, feeds it to a `booth_enc` instance, and turns the `y`/`y2`/`neg` controls into a partial product. It then accumulates that product into a 2·WIDTH-bit result with a start/busy/done handshake.

## Interface
- `WIDTH`, 8: operand width in bits. Must be even and at least 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a multiply. Sampled only in IDLE.
- `a`  in  WIDTH  multiplicand, signed two's complement. Sampled with `start`.
- `b`  in  WIDTH  multiplier, signed two's complement. Sampled with `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse, high while in DONE.
- `product`  out  2·WIDTH  signed a·b. Registered; holds until the next completion.

## Operation
- States and transitions:
  - IDLE: `start`=1 → RUN. Otherwise stay in IDLE.
  - RUN: stay for exactly WIDTH/2 cycles, then → DONE.
  - DONE: always → IDLE after one cycle.
- Load on the IDLE edge with `start`=1:
  - `areg` ← sign-extend(a) to 2·WIDTH.
  - `mreg` ← {b, 1'b0}, WIDTH+1 bits.
  - `acc` ← 0.
  - `cnt` ← 0.
- Each RUN cycle:
  - Window = `mreg[2:0]`, applied to the `booth_enc` `xin` input.
  - Magnitude selection: `y`=1 → `areg`; `y2`=1 → `areg`<<1; both 0 → 0.
  - `neg`=1 → two's-complement negate the magnitude. Window 7 gives −0 = 0.
  - `acc` ← `acc` + (pp << 2·cnt), all arithmetic modulo 2^(2·WIDTH).
  - `mreg` ← arithmetic shift right by 2, replicating the sign bit.
  - `cnt` ← `cnt` + 1. Width of `cnt` is $clog2(WIDTH/2), minimum 1.
- Last RUN cycle: `product` ← final `acc` value, including this cycle's partial product. State → DONE.
- `start` is ignored outside IDLE (RUN and DONE): it is neither queued nor able to corrupt the operation in flight.
- `a`/`b` may change freely after the load edge.
- `product` keeps its value through later RUN cycles and changes only on the completion edge.

## Timing
- Reset values, all immediate on `rst_n` low:
  - state = IDLE.
  - `busy` = 0, `done` = 0, `product` = 0.
  - `acc` = 0, `mreg` = 0, `cnt` = 0.
- Reset asserted mid-operation aborts the operation. No `done` is issued, and `product` reads 0.
- With `start` sampled at edge k:
  - `busy`=1 from edge k through edge k+WIDTH/2+1.
  - RUN occupies edges k+1 … k+WIDTH/2. The last of these writes `product`.
  - `done`=1 and `product` is valid during the cycle after edge k+WIDTH/2.
  - Back in IDLE after edge k+WIDTH/2+1.
- Latency: WIDTH/2+1 cycles from the `start` edge to `done`. At WIDTH=8: `done` in the cycle after edge k+4.
- Back-to-back: the earliest next `start` accepted is at edge k+WIDTH/2+2, so initiation interval = WIDTH/2+2.
- Outputs are purely registered. No combinational path from inputs to outputs.

## Structure
- Shared package `booth_pkg`:
  - State enum {IDLE, RUN, DONE}.
  - Booth control encodings matching `booth_enc`: 000 zero, 100 +A, 010 +2A, 011 −2A, 101 −A, 001 −0.
- Sub-module: existing `booth_enc`, one instance, combinational.
- Partial-product select/negate is inline logic in `booth_mul_seq`; no further sub-module.

## Test plan
All scenarios use WIDTH=8 unless noted.
- a=3, b=5 → `product`=15. `done` high exactly in the cycle after edge k+4. `busy` high for 5 cycles.
- a=−128, b=−128 → `product`=16384 (0x4000). a=127, b=−128 → `product`=−16256 (0xC080).
- a=0x55, b=0 → 0. a=−1, b=−1 → 1. a=−1, b=1 → 0xFFFF.
- Start while busy: `start` held high for all cycles with a=7, b=9, operands changed to 2, 2 after the load edge → first `product`=63. The next operation is accepted only in IDLE, at edge k+6.
- Reset mid-op: `rst_n` pulsed low during RUN edge k+2 → `busy`=0, `product`=0, no `done`. Next a=−5, b=6 → −30.
- WIDTH=4, exhaustive 256 signed pairs versus a reference model → all match; latency 3 cycles.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states and digit controls.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit control word, bit order {y, y2, neg}
  typedef struct packed {
    logic y;
    logic y2;
    logic neg;
  } booth_ctrl_t;

  localparam booth_ctrl_t CTRL_ZERO  = 3'b000;
  localparam booth_ctrl_t CTRL_P1A   = 3'b100;
  localparam booth_ctrl_t CTRL_P2A   = 3'b010;
  localparam booth_ctrl_t CTRL_N2A   = 3'b011;
  localparam booth_ctrl_t CTRL_N1A   = 3'b101;
  localparam booth_ctrl_t CTRL_NZERO = 3'b001;

  // Map an overlapping 3-bit multiplier window onto its Booth digit control
  function automatic booth_ctrl_t booth_decode(input logic [2:0] win);
    booth_ctrl_t ctrl;
    case (win)
      3'b000:  ctrl = CTRL_ZERO;
      3'b001:  ctrl = CTRL_P1A;
      3'b010:  ctrl = CTRL_P1A;
      3'b011:  ctrl = CTRL_P2A;
      3'b100:  ctrl = CTRL_N2A;
      3'b101:  ctrl = CTRL_N1A;
      3'b110:  ctrl = CTRL_N1A;
      default: ctrl = CTRL_NZERO;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/booth_enc.sv
// Combinational radix-4 Booth digit encoder.
module booth_enc
  import booth_pkg::*;
(
  input  logic [2:0] xin,
  output logic       y,
  output logic       y2,
  output logic       neg
);

  booth_ctrl_t ctrl;

  // Decode the window into select/negate controls
  always_comb begin
    ctrl = booth_decode(xin);
    y    = ctrl.y;
    y2   = ctrl.y2;
    neg  = ctrl.neg;
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit accumulated per clock.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned MW    = WIDTH + 1;
  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  state_t           state;
  logic [PW-1:0]    areg;
  logic [PW-1:0]    acc;
  logic [MW-1:0]    mreg;
  logic [CNT_W-1:0] cnt;

  logic             y;
  logic             y2;
  logic             neg;
  logic [CNT_W:0]   shamt_c;
  logic [PW-1:0]    mag_c;
  logic [PW-1:0]    pp_c;
  logic [PW-1:0]    acc_next_c;

  booth_enc u_enc (
    .xin (mreg[2:0]),
    .y   (y),
    .y2  (y2),
    .neg (neg)
  );

  // Partial product for the current digit, weighted and added to the accumulator
  always_comb begin
    shamt_c = {cnt, 1'b0};
    mag_c   = '0;
    if (y) begin
      mag_c = areg;
    end else if (y2) begin
      mag_c = areg << 1;
    end
    pp_c       = neg ? (~mag_c + PW'(1)) : mag_c;
    acc_next_c = acc + (pp_c << shamt_c);
  end

  // Control FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      areg    <= '0;
      acc     <= '0;
      mreg    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            areg  <= {{WIDTH{a[WIDTH-1]}}, a};
            mreg  <= {b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_next_c;
          mreg <= {{2{mreg[MW-1]}}, mreg[MW-1:2]};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            product <= acc_next_c;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq at WIDTH=8 and WIDTH=4.
module tb_booth_mul_seq;

  logic        clk;
  logic        rst_n;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] prod8;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [7:0]  prod4;

  int checks = 0;
  int passed = 0;

  booth_mul_seq #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start8),
    .a       (a8),
    .b       (b8),
    .busy    (busy8),
    .done    (done8),
    .product (prod8)
  );

  booth_mul_seq #(.WIDTH(4)) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start4),
    .a       (a4),
    .b       (b4),
    .busy    (busy4),
    .done    (done4),
    .product (prod4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Signed reference products from plain integer arithmetic
  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] z);
    int sx = $signed(x);
    int sz = $signed(z);
    return 16'(sx * sz);
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] z);
    int sx = $signed(x);
    int sz = $signed(z);
    return 8'(sx * sz);
  endfunction

  // Run one WIDTH=8 operation from IDLE; returns product, edges to done, busy cycles
  task automatic op8(input logic [7:0] a_i, input logic [7:0] b_i, input string nm,
                     output logic [15:0] p, output int lat, output int busy_cyc);
    start8 = 1'b1; a8 = a_i; b8 = b_i;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0; busy_cyc = 0;
    while (!done8 && lat < 20) begin
      if (busy8) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy8) busy_cyc++;
    p = prod8;
    @(posedge clk); #1;
    chk({nm, "_done_drop"}, 64'(done8), 64'(0));
    chk({nm, "_busy_drop"}, 64'(busy8), 64'(0));
  endtask

  task automatic op4(input logic [3:0] a_i, input logic [3:0] b_i,
                     output logic [7:0] p, output int lat);
    start4 = 1'b1; a4 = a_i; b4 = b_i;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    p = prod4;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] p;
    logic [7:0]  p4;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        seen;
    int          lat;
    int          bc;

    vecs[0] = '{8'd3,   8'd5,   16'd15};
    vecs[1] = '{8'h80,  8'h80,  16'h4000};
    vecs[2] = '{8'h7F,  8'h80,  16'hC080};
    vecs[3] = '{8'h55,  8'h00,  16'h0000};
    vecs[4] = '{8'hFF,  8'hFF,  16'h0001};
    vecs[5] = '{8'hFF,  8'h01,  16'hFFFF};

    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("reset_busy",    64'(busy8), 64'(0));
    chk("reset_done",    64'(done8), 64'(0));
    chk("reset_product", 64'(prod8), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      op8(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), p, lat, bc);
      chk($sformatf("vec%0d_product", i), 64'(p), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(4));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(5));
    end

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op8(ra, rb, $sformatf("rnd%0d", i), p, lat, bc);
      chk($sformatf("rnd%0d_product", i), 64'(p), 64'(ref8(ra, rb)));
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(4));
    end

    // start held high throughout, operands changed after load
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd9;
    @(posedge clk); #1;
    a8 = 8'd2; b8 = 8'd2;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_run%0d_done", i), 64'(done8), 64'(0));
      chk($sformatf("hold_run%0d_busy", i), 64'(busy8), 64'(1));
    end
    @(posedge clk); #1;
    chk("hold_first_done",    64'(done8), 64'(1));
    chk("hold_first_product", 64'(prod8), 64'(63));
    @(posedge clk); #1;
    chk("hold_idle_busy",     64'(busy8), 64'(0));
    chk("hold_idle_done",     64'(done8), 64'(0));
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("hold_second_accept", 64'(busy8), 64'(1));
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold2_run%0d_product", i), 64'(prod8), 64'(63));
    end
    @(posedge clk); #1;
    chk("hold_second_done",    64'(done8), 64'(1));
    chk("hold_second_product", 64'(prod8), 64'(4));
    @(posedge clk); #1;

    // Reset asserted mid-operation
    start8 = 1'b1; a8 = 8'd11; b8 = 8'd13;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",    64'(busy8), 64'(0));
    chk("midrst_product", 64'(prod8), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | done8 | busy8;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", 64'(seen), 64'(0));
    op8(8'hFB, 8'd6, "after_rst", p, lat, bc);
    chk("after_rst_product", 64'(p), 64'(16'hFFE2));

    // WIDTH=4 exhaustive
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        op4(4'(i), 4'(j), p4, lat);
        chk($sformatf("w4_%0d_%0d_product", i, j), 64'(p4), 64'(ref4(4'(i), 4'(j))));
        chk($sformatf("w4_%0d_%0d_latency", i, j), 64'(lat), 64'(2));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
